// File: rtl/mvm_driver.sv
// ---------------------------------------------------------------------------
// mvm_driver
// Initiator-side sequencer for the mvm crossbar block. Accepts a command,
// streams operands in from a serial load port, fires the crossbar with a
// single-cycle pulse, waits for completion (bounded by TIMEOUT cycles) and
// returns the XBAR_SIZE results as a valid/ready stream.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   cmd_valid/ready/op      command handshake (0=MVM 1=PROG_WT 2=RESET_WT 3=nop)
//   ld_valid/ready/data     operand load stream (low IN_BITS used for inputs)
//   res_valid/ready/data    result stream, res_last marks the final word
//   res_last
//   mvm_start, prog_wt,     one-cycle pulses toward mvm
//   reset_wt
//   xbar_input, wr_weight   registered operand arrays toward mvm
//   mvm_done, xbar_output   completion and results from mvm
//   busy                    sequencer not idle
//   err_timeout             sticky abort flag, cleared by reset or new command
// ---------------------------------------------------------------------------
module mvm_driver #(
    parameter int XBAR_SIZE = 16,
    parameter int IN_BITS   = 16,
    parameter int WT_BITS   = 16,
    parameter int OUT_BITS  = 32,
    parameter int TIMEOUT   = 1024,
    localparam int LD_BITS  = (IN_BITS > WT_BITS) ? IN_BITS : WT_BITS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [1:0]                                cmd_op,
    input  logic                                      ld_valid,
    output logic                                      ld_ready,
    input  logic [LD_BITS-1:0]                        ld_data,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [OUT_BITS-1:0]                       res_data,
    output logic                                      res_last,
    output logic                                      mvm_start,
    output logic                                      prog_wt,
    output logic                                      reset_wt,
    output logic [XBAR_SIZE-1:0][IN_BITS-1:0]         xbar_input,
    output logic [XBAR_SIZE*XBAR_SIZE-1:0][WT_BITS-1:0] wr_weight,
    input  logic                                      mvm_done,
    input  logic [XBAR_SIZE-1:0][OUT_BITS-1:0]        xbar_output,
    output logic                                      busy,
    output logic                                      err_timeout
);

    localparam int NWT   = XBAR_SIZE * XBAR_SIZE;
    localparam int IDX_W = $clog2(NWT);
    localparam int SEL_W = $clog2(XBAR_SIZE);
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    localparam logic [IDX_W-1:0] LAST_IN = IDX_W'(XBAR_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_WT = IDX_W'(NWT - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_IN = 3'd1,
        S_LOAD_WT = 3'd2,
        S_FIRE    = 3'd3,
        S_FIRE_WT = 3'd4,
        S_WAIT    = 3'd5,
        S_DRAIN   = 3'd6,
        S_RST_WT  = 3'd7
    } state_t;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [TO_W-1:0]                     to_cnt_q, to_cnt_d;
    logic                                op_wt_q;
    logic                                err_q;
    logic [XBAR_SIZE-1:0][IN_BITS-1:0]   xin_q;
    logic [NWT-1:0][WT_BITS-1:0]         wt_q;
    logic [XBAR_SIZE-1:0][OUT_BITS-1:0]  buf_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done beats the timeout when both land on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'd0:    state_d = S_LOAD_IN;
                        2'd1:    state_d = S_LOAD_WT;
                        2'd2:    state_d = S_RST_WT;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_IN: begin
                if (ld_valid && (idx_q == LAST_IN)) state_d = S_FIRE;
                else                                state_d = S_LOAD_IN;
            end
            S_LOAD_WT: begin
                if (ld_valid && (idx_q == LAST_WT)) state_d = S_FIRE_WT;
                else                                state_d = S_LOAD_WT;
            end
            S_FIRE:    state_d = S_WAIT;
            S_FIRE_WT: state_d = S_WAIT;
            S_WAIT: begin
                if (mvm_done)                 state_d = op_wt_q ? S_IDLE : S_DRAIN;
                else if (to_cnt_q == TO_LAST) state_d = S_IDLE;
                else                          state_d = S_WAIT;
            end
            S_DRAIN: begin
                if (res_ready && (idx_q == LAST_IN)) state_d = S_IDLE;
                else                                 state_d = S_DRAIN;
            end
            S_RST_WT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode, purely from registered state
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        ld_ready  = (state_q == S_LOAD_IN) || (state_q == S_LOAD_WT);
        res_valid = (state_q == S_DRAIN);
        mvm_start = (state_q == S_FIRE);
        prog_wt   = (state_q == S_FIRE_WT);
        reset_wt  = (state_q == S_RST_WT);
        busy      = (state_q != S_IDLE);
        if (state_q == S_DRAIN) begin
            res_data = buf_q[idx_q[SEL_W-1:0]];
            res_last = (idx_q == LAST_IN);
        end else begin
            res_data = {OUT_BITS{1'b0}};
            res_last = 1'b0;
        end
    end

    // Index and timeout counter next values; idx wraps to 0 after a final word
    always_comb begin
        idx_d    = idx_q;
        to_cnt_d = {TO_W{1'b0}};
        case (state_q)
            S_LOAD_IN: begin
                if (ld_valid) idx_d = (idx_q == LAST_IN) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
                else          idx_d = idx_q;
            end
            S_LOAD_WT: begin
                if (ld_valid) idx_d = (idx_q == LAST_WT) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
                else          idx_d = idx_q;
            end
            S_WAIT: begin
                idx_d    = {IDX_W{1'b0}};
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
            S_DRAIN: begin
                if (res_ready) idx_d = (idx_q == LAST_IN) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
                else           idx_d = idx_q;
            end
            default: idx_d = {IDX_W{1'b0}};
        endcase
    end

    // Counters, op flag, sticky error and operand/result storage
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= {IDX_W{1'b0}};
            to_cnt_q <= {TO_W{1'b0}};
            op_wt_q  <= 1'b0;
            err_q    <= 1'b0;
            xin_q    <= '0;
            wt_q     <= '0;
            buf_q    <= '0;
        end else begin
            idx_q    <= idx_d;
            to_cnt_q <= to_cnt_d;
            if (state_q == S_IDLE && cmd_valid) begin
                op_wt_q <= (cmd_op == 2'd1);
                err_q   <= 1'b0;
            end else if (state_q == S_WAIT && !mvm_done && to_cnt_q == TO_LAST) begin
                err_q   <= 1'b1;
            end
            if (state_q == S_LOAD_IN && ld_valid) begin
                xin_q[idx_q[SEL_W-1:0]] <= ld_data[IN_BITS-1:0];
            end
            if (state_q == S_LOAD_WT && ld_valid) begin
                wt_q[idx_q] <= ld_data[WT_BITS-1:0];
            end
            if (state_q == S_RST_WT) begin
                wt_q <= '0;
            end
            if (state_q == S_WAIT && mvm_done && !op_wt_q) begin
                buf_q <= xbar_output;
            end
        end
    end

    assign xbar_input  = xin_q;
    assign wr_weight   = wt_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mvm_driver.sv
module tb_mvm_driver;

    localparam int XS = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [1:0]              cmd_op = 2'd0;
    logic                    ld_valid = 1'b0;
    logic                    ld_ready;
    logic [15:0]             ld_data = 16'd0;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic [31:0]             res_data;
    logic                    res_last;
    logic                    mvm_start, prog_wt, reset_wt;
    logic [XS-1:0][15:0]     xbar_input;
    logic [XS*XS-1:0][15:0]  wr_weight;
    logic                    mvm_done;
    logic                    model_done = 1'b0;
    logic                    stray_done = 1'b0;
    logic                    model_en = 1'b1;
    logic [XS-1:0][31:0]     xbar_output = '0;
    logic                    busy, err_timeout;

    assign mvm_done = model_done | stray_done;

    mvm_driver #(
        .XBAR_SIZE(XS), .IN_BITS(16), .WT_BITS(16), .OUT_BITS(32), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .mvm_start(mvm_start), .prog_wt(prog_wt), .reset_wt(reset_wt),
        .xbar_input(xbar_input), .wr_weight(wr_weight),
        .mvm_done(mvm_done), .xbar_output(xbar_output),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] d; logic l; } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0, n_prog = 0, n_rst = 0;
    logic [15:0] ld_buf [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] op);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!cmd_ready && n < 100) begin step(); n++; end
        if (!cmd_ready) timeout_fail("cmd_wait");
        step();
        cmd_valid = 1'b0;
    endtask

    // Sends cnt words from ld_buf; before word stall_at, ld_valid drops for 3 cycles
    task automatic load(input int cnt, input int stall_at);
        int n;
        for (int k = 0; k < cnt; k++) begin
            if (k == stall_at) begin
                ld_valid = 1'b0;
                repeat (3) step();
            end
            ld_valid = 1'b1;
            ld_data  = ld_buf[k];
            n = 0;
            while (!ld_ready && n < 100) begin step(); n++; end
            if (!ld_ready) timeout_fail("ld_wait");
            step();
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin step(); n++; end
        if (busy) timeout_fail(name);
    endtask

    task automatic wait_res_valid();
        int n;
        n = 0;
        while (!res_valid && n < 200) begin step(); n++; end
        if (!res_valid) timeout_fail("res_valid_wait");
    endtask

    // mvm model: answers each pulse 5 cycles later with 10x the input vector
    initial begin
        forever begin
            @(negedge clk);
            if ((mvm_start || prog_wt) && model_en) begin
                repeat (5) @(negedge clk);
                for (int i = 0; i < XS; i++) xbar_output[i] = 32'(xbar_input[i]) * 32'd10;
                model_done = 1'b1;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: pulse accounting, result pops and stall stability
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (mvm_start) n_start++;
            if (prog_wt)   n_prog++;
            if (reset_wt)  n_rst++;
            if (mvm_start || prog_wt || reset_wt)
                check("pulse_excl", 64'(int'(mvm_start) + int'(prog_wt) + int'(reset_wt)), 64'd1);
            if (!reset && res_valid) begin
                if (prev_stall) check("res_hold", {31'd0, res_last, res_data}, {31'd0, prev_last, prev_data});
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL res_unexpected: got %0h, expected no result", res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", 64'(res_data), 64'(e.d));
                        check("res_last", 64'(res_last), 64'(e.l));
                    end
                end
                prev_stall = !res_ready;
                prev_data  = res_data;
                prev_last  = res_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        // Reset state
        repeat (3) step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_err",       64'(err_timeout), 64'd0);
        check("rst_xin",       64'(xbar_input), 64'd0);
        check("rst_wt",        64'(wr_weight == '0), 64'd1);
        reset = 1'b0;
        step();

        // Test 1: basic MVM, words 1..4 -> results 10..40
        push_exp(32'd10, 1'b0); push_exp(32'd20, 1'b0);
        push_exp(32'd30, 1'b0); push_exp(32'd40, 1'b1);
        res_ready = 1'b1;
        ld_buf[0] = 16'd1; ld_buf[1] = 16'd2; ld_buf[2] = 16'd3; ld_buf[3] = 16'd4;
        base = n_start;
        send_cmd(2'd0);
        load(4, -1);
        check("t1_fire", 64'(mvm_start), 64'd1);
        check("t1_xin",  64'(xbar_input), 64'h0004_0003_0002_0001);
        n = 0;
        while (!(res_valid && res_last) && n < 200) begin step(); n++; end
        if (!(res_valid && res_last)) timeout_fail("t1_last_wait");
        step();
        check("t1_busy_after",  64'(busy), 64'd0);
        check("t1_valid_after", 64'(res_valid), 64'd0);
        check("t1_start_cnt",   64'(n_start - base), 64'd1);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Test 3: ld stall mid-vector, then res_ready pattern 1,0,0,1,0,1,1
        res_ready = 1'b0;
        push_exp(32'd10, 1'b0); push_exp(32'd20, 1'b0);
        push_exp(32'd30, 1'b0); push_exp(32'd40, 1'b1);
        send_cmd(2'd0);
        load(4, 2);
        check("t3_xin", 64'(xbar_input), 64'h0004_0003_0002_0001);
        wait_res_valid();
        begin
            logic [6:0] pat;
            pat = 7'b1101001;
            for (int i = 0; i < 7; i++) begin
                res_ready = pat[i];
                step();
            end
        end
        res_ready = 1'b0;
        check("t3_busy_after",  64'(busy), 64'd0);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // Test 2: PROG_WT with words 0..15, no results expected
        res_ready = 1'b1;
        for (int k = 0; k < 16; k++) ld_buf[k] = 16'(k);
        base = n_prog;
        send_cmd(2'd1);
        load(16, -1);
        check("t2_fire", 64'(prog_wt), 64'd1);
        for (int k = 0; k < 16; k++) check($sformatf("t2_wt%0d", k), 64'(wr_weight[k]), 64'(k));
        wait_idle("t2_idle_wait");
        step();
        check("t2_prog_cnt",  64'(n_prog - base), 64'd1);
        check("t2_res_valid", 64'(res_valid), 64'd0);

        // Test 5a: RESET_WT clears the weight copy with one pulse
        base = n_rst;
        send_cmd(2'd2);
        check("t5_rst_pulse", 64'(reset_wt), 64'd1);
        wait_idle("t5_idle_wait");
        step();
        check("t5_rst_cnt",   64'(n_rst - base), 64'd1);
        check("t5_wt_clear",  64'(wr_weight == '0), 64'd1);

        // Test 4: timeout with no mvm_done; err registers on the edge closing
        // the 8th WAIT_DONE cycle, i.e. 8 edges after the pulse ends
        model_en = 1'b0;
        ld_buf[0] = 16'd1; ld_buf[1] = 16'd1; ld_buf[2] = 16'd1; ld_buf[3] = 16'd1;
        send_cmd(2'd0);
        load(4, -1);
        check("t4_fire", 64'(mvm_start), 64'd1);
        for (int j = 1; j <= 9; j++) begin
            step();
            if (j == 8) begin
                check("t4_err_early",  64'(err_timeout), 64'd0);
                check("t4_busy_early", 64'(busy), 64'd1);
            end
        end
        check("t4_err_set", 64'(err_timeout), 64'd1);
        check("t4_idle",    64'(busy), 64'd0);
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        step();
        check("t4_stray_idle", 64'(busy), 64'd0);
        check("t4_err_sticky", 64'(err_timeout), 64'd1);
        send_cmd(2'd3);
        check("t4_err_clear", 64'(err_timeout), 64'd0);
        check("t4_nop_idle",  64'(busy), 64'd0);
        model_en = 1'b1;

        // Test 5b: reset during DRAIN at idx 2
        res_ready = 1'b0;
        push_exp(32'd20, 1'b0); push_exp(32'd40, 1'b0);
        ld_buf[0] = 16'd2; ld_buf[1] = 16'd4; ld_buf[2] = 16'd6; ld_buf[3] = 16'd8;
        send_cmd(2'd0);
        load(4, -1);
        wait_res_valid();
        res_ready = 1'b1;
        step();
        step();
        res_ready = 1'b0;
        check("t5_idx2_data", 64'(res_data), 64'd60);
        reset = 1'b1;
        step();
        check("t5_rst_valid", 64'(res_valid), 64'd0);
        check("t5_rst_idle",  64'(busy), 64'd0);
        check("t5_rst_xin",   64'(xbar_input), 64'd0);
        reset = 1'b0;
        step();

        // Fresh MVM after reset
        res_ready = 1'b1;
        push_exp(32'd30, 1'b0); push_exp(32'd10, 1'b0);
        push_exp(32'd40, 1'b0); push_exp(32'd10, 1'b1);
        ld_buf[0] = 16'd3; ld_buf[1] = 16'd1; ld_buf[2] = 16'd4; ld_buf[3] = 16'd1;
        send_cmd(2'd0);
        load(4, -1);
        wait_idle("t5_fresh_wait");
        step();
        check("t5_fresh_empty", 64'(exp_q.size()), 64'd0);
        check("t5_fresh_err",   64'(err_timeout), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mvm_driver.md
Name: mvm_driver

Overview:
- Initiator-side sequencer for the mvm block. It owns mvm_start, prog_wt and reset_wt, and drives the xbar_input and wr_weight arrays. It consumes mvm_done and xbar_output.
- Accepts commands from the tile control path and loads operands from a serial load stream. It fires the crossbar, waits for completion, then returns the XBAR_SIZE results as a valid/ready stream.

Parameters:
- XBAR_SIZE, 16, crossbar dimension (must equal `xbar_size).
- IN_BITS, 16, input element width (`xbar_in_bits).
- WT_BITS, 16, weight width (`wt_bits); ld_data width is max(IN_BITS, WT_BITS).
- OUT_BITS, 32, output element width (`xbar_out_bits).
- TIMEOUT, 1024, maximum cycles in WAIT_DONE before abort.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=MVM, 1=PROG_WT, 2=RESET_WT, 3=reserved.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  high in LOAD_IN/LOAD_WT.
- ld_data  in  max(IN_BITS,WT_BITS)  operand word; low IN_BITS used for inputs.
- res_valid  out  1  result word valid.
- res_ready  in  1  result consumer ready.
- res_data  out  OUT_BITS  result word.
- res_last  out  1  marks result index XBAR_SIZE-1.
- mvm_start  out  1  one-cycle pulse to mvm.
- prog_wt  out  1  one-cycle pulse to mvm.
- reset_wt  out  1  one-cycle pulse to mvm.
- xbar_input  out  IN_BITS x XBAR_SIZE  registered input vector.
- wr_weight  out  WT_BITS x XBAR_SIZE^2  registered weight array.
- mvm_done  in  1  completion from mvm.
- xbar_output  in  OUT_BITS x XBAR_SIZE  mvm results.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky abort flag; cleared only by reset or accepted command.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-operation): state=IDLE; all counters 0; xbar_input, wr_weight and the result buffer cleared to 0; mvm_start, prog_wt, reset_wt, res_valid, res_last, busy, err_timeout all 0; res_data 0. Reset never pulses reset_wt.
- Command acceptance: handshake at cmd_valid&&cmd_ready. Accepting any command clears err_timeout.
  - op 0 goes to LOAD_IN.
  - op 1 goes to LOAD_WT.
  - op 2 goes to RST_WT.
  - op 3 is accepted and dropped; stays IDLE.
- LOAD_IN: each ld handshake writes xbar_input[idx], with idx from 0 up. On the handshake where idx==XBAR_SIZE-1, go to FIRE. No partial vectors; the loader stalls indefinitely while ld_valid is low.
- LOAD_WT: same as LOAD_IN, but XBAR_SIZE^2 words written row-major into wr_weight[idx]. The last word goes to FIRE_WT.
- FIRE / FIRE_WT: one cycle.
  - FIRE asserts mvm_start; FIRE_WT asserts prog_wt.
  - Next state is WAIT_DONE; the timeout counter is cleared.
  - Operand arrays hold stable from the pulse until the return to IDLE.
- WAIT_DONE: the timeout counter increments each cycle.
  - mvm_done=1, MVM op: capture all xbar_output into the result buffer the same cycle, then go to DRAIN with idx=0.
  - mvm_done=1, PROG_WT op: go to IDLE.
  - counter==TIMEOUT-1 with no mvm_done: set err_timeout and go to IDLE. No results are emitted.
  - mvm_done arriving on the timeout cycle: done wins.
  - The earliest legal mvm_done is the cycle after the pulse. mvm_done in any other state is ignored.
- DRAIN:
  - res_valid=1; res_data=buffer[idx]; res_last=(idx==XBAR_SIZE-1).
  - res_data and res_last hold stable while res_ready=0.
  - On handshake idx increments. The last handshake returns to IDLE with res_valid low the next cycle.
  - Maximum throughput is one word per cycle.
- RST_WT: one cycle with reset_wt=1, also clearing the local wr_weight copy to 0. Next state is IDLE.
- Pulses are exactly one cycle and mutually exclusive. There is no back-to-back command overlap: cmd_ready stays low from acceptance until the cycle after return to IDLE, where IDLE is entered.
- Latency for an MVM command, with ld_valid and res_ready held high and done latency D cycles after mvm_start: XBAR_SIZE load cycles + 1 fire cycle + D cycles + XBAR_SIZE drain cycles.

Test Plan:
- Bench uses XBAR_SIZE=4 unless stated.
- Test 1, MVM basic: cmd_op=0, ld words 1,2,3,4.
  - Required: xbar_input={1,2,3,4}; mvm_start pulses once.
  - Model asserts mvm_done 5 cycles later with xbar_output={10,20,30,40}.
  - Required: res stream 10,20,30,40 with res_last on 40; busy falls after the last handshake.
- Test 2, PROG_WT: cmd_op=1, 16 words 0..15.
  - Required: wr_weight[k]=k; one prog_wt pulse; mvm_done returns to IDLE with no res_valid.
- Test 3, backpressure: during test 1's drain, toggle res_ready 1,0,0,1,0,1,1.
  - Required: each result appears exactly once, in order; res_data stable while stalled.
  - Ld stall: ld_valid low 3 cycles mid-vector; required loaded vector is unchanged.
- Test 4, timeout: TIMEOUT=8, no mvm_done.
  - Required: err_timeout=1 exactly 8 cycles after mvm_start; IDLE; no results.
  - Next accepted command clears err_timeout.
  - A stray mvm_done in IDLE is ignored.
- Test 5, RESET_WT and reset: cmd_op=2 after test 2.
  - Required: one reset_wt pulse; wr_weight all 0.
  - Separately, assert reset during DRAIN at idx=2. Required next cycle: res_valid=0, IDLE, xbar_input=0.
  - A fresh MVM command then completes normally.
